shift_rx32: RTL and testbench

SHIFT_RX32 -- requirements
Module: shift_rx32

---
 rtl/shift_rx32_pkg.sv | 24 ++
 rtl/shift_rx32_cont_bits.sv | 48 ++++
 rtl/shift_rx32.sv | 112 +++++++++++
 tb/tb_shift_rx32.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_rx32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_rx32_pkg
// Description : Shared types and constants for the serial-to-parallel
//               word receiver (state encoding, default width, counter sizing).
// Revision    : 1.0 - initial release
// ============================================================================
package shift_rx32_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CAPT = 2'b01,
    HOLD = 2'b10
  } state_e;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_rx32_cont_bits.sv
`default_nettype none
// ============================================================================
// Module      : cont_bits
// Description : Captured-bit counter with synchronous clear, increment enable
//               and a terminal-count flag that is high while the next
//               increment will complete the word.
// Revision    : 1.0 - initial release
// ============================================================================
module cont_bits
  import shift_rx32_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over increment, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // WIDTH-1 bits already in: the next accepted bit is the last one.
  assign tc = (cnt_q == CW'(WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/shift_rx32.sv
`default_nettype none
// ============================================================================
// Module      : shift_rx32
// Description : Serial-to-parallel receiver. A start pulse in IDLE begins
//               capture of WIDTH qualified bits (LSB- or MSB-first), the word
//               is then held with valid until acknowledged. Starts arriving
//               while a word is held unacknowledged raise a sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rx32
  import shift_rx32_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             enb,
  input  logic             dir,
  input  logic             sIn,
  input  logic             ack,
  output logic [WIDTH-1:0] Q,
  output logic             valid,
  output logic             busy,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_tc;

  cont_bits #(
    .WIDTH (WIDTH)
  ) u_cont_bits (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .tc  (cnt_tc)
  );

  // Next-state, shifter and overrun logic.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    dir_d   = dir_q;
    err_d   = err_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAPT;
          cnt_clr = 1'b1;
          dir_d   = dir;
          err_d   = 1'b0;
        end
      end
      CAPT: begin
        // Repeated start is ignored here; only enb advances the capture.
        if (enb) begin
          cnt_inc = 1'b1;
          if (dir_q) begin
            q_d = {sIn, q_q[WIDTH-1:1]};
          end else begin
            q_d = {q_q[WIDTH-2:0], sIn};
          end
          if (cnt_tc) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // A start coinciding with ack is simply dropped.
        if (ack) begin
          state_d = IDLE;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, data and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign Q     = q_q;
  assign valid = (state_q == HOLD);
  assign busy  = (state_q == CAPT);
  assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_rx32.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_rx32
// Description : Self-checking bench for shift_rx32: directed word scenarios
//               with literal expectations plus a randomized run, all checked
//               every cycle against a word-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_rx32;

  logic        clk = 1'b0;
  logic        rst, start, enb, dir, sIn, ack;
  logic [31:0] Q;
  logic        valid, busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  shift_rx32 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .enb   (enb),
    .dir   (dir),
    .sIn   (sIn),
    .ack   (ack),
    .Q     (Q),
    .valid (valid),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (word level) ----------------
  // phase: 0 = waiting for start, 1 = collecting bits, 2 = word offered
  int          m_phase = 0;
  int          m_nbits = 0;
  bit          m_bits[32];
  bit          m_lsb_first = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_word = '0;
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_nbits = 0; m_word = '0; m_err = 1'b0; m_live = 1'b1;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1; m_nbits = 0; m_lsb_first = dir; m_err = 1'b0;
      end
    end else if (m_phase == 1) begin
      if (enb) begin
        m_bits[m_nbits] = sIn;
        m_nbits++;
        if (m_nbits == 32) begin
          // i-th received bit lands at bit i (LSB first) or 31-i (MSB first).
          for (int i = 0; i < 32; i++) begin
            if (m_lsb_first) m_word[i] = m_bits[i];
            else             m_word[31-i] = m_bits[i];
          end
          m_phase = 2;
        end
      end
    end else begin
      if (ack)        m_phase = 0;
      else if (start) m_err = 1'b1;
    end
  end

  // Every-cycle comparison; Q is only defined outside an active capture.
  always @(negedge clk) begin
    if (m_live) begin
      check("busy",  {31'd0, busy},  {31'd0, m_phase == 1});
      check("valid", {31'd0, valid}, {31'd0, m_phase == 2});
      check("err",   {31'd0, err},   {31'd0, m_err});
      if (m_phase != 1) check("Q", Q, m_word);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input bit st, input bit en, input bit si, input bit ak, input bit rs, input bit dr);
    start = st; enb = en; sIn = si; ack = ak; rst = rs; dir = dr;
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input bit d, input int first, input int last,
                           input int restart_at, input bit gaps);
    int i;
    int c;
    i = first;
    c = 0;
    while (i <= last) begin
      if (gaps && (c % 3 == 2)) begin
        tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, d);
      end else begin
        tick(i == restart_at, 1'b1, d ? w[i] : w[31-i], 1'b0, 1'b0, d);
        i++;
      end
      c++;
    end
  endtask

  task automatic do_ack(input bit d);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, d);
    check("ack_valid", {31'd0, valid}, 32'd0);
    check("ack_busy",  {31'd0, busy},  32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; enb = 1'b0; dir = 1'b0; sIn = 1'b0; ack = 1'b0;
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 1, 1, 1, 1, 1);
    check("rst_Q", Q, 32'h0);
    check("rst_flags", {29'd0, valid, busy, err}, 32'd0);

    // LSB-first word
    tick(1, 0, 0, 0, 0, 1);
    check("start_busy", {31'd0, busy}, 32'd1);
    send_bits(32'hA5A50F3C, 1, 0, 30, -1, 0);
    check("lsb_pre_valid", {31'd0, valid}, 32'd0);
    send_bits(32'hA5A50F3C, 1, 31, 31, -1, 0);
    check("lsb_valid", {31'd0, valid}, 32'd1);
    check("lsb_busy",  {31'd0, busy},  32'd0);
    check("lsb_Q", Q, 32'hA5A50F3C);
    do_ack(1);

    // MSB-first word, held for 5 cycles before ack
    tick(1, 0, 0, 0, 0, 0);
    send_bits(32'h80000001, 0, 0, 31, -1, 0);
    for (int k = 0; k < 5; k++) begin
      tick(0, 1, 1, 0, 0, 0);
      check("msb_hold_Q", Q, 32'h80000001);
      check("msb_hold_valid", {31'd0, valid}, 32'd1);
    end
    do_ack(0);
    check("msb_idle_Q", Q, 32'h80000001);

    // enb gaps every third cycle
    tick(1, 0, 0, 0, 0, 1);
    send_bits(32'h12345678, 1, 0, 30, -1, 1);
    check("gap_pre_valid", {31'd0, valid}, 32'd0);
    send_bits(32'h12345678, 1, 31, 31, -1, 0);
    check("gap_valid", {31'd0, valid}, 32'd1);
    check("gap_Q", Q, 32'h12345678);
    do_ack(1);

    // Overrun, then start+ack in HOLD drops the start
    tick(1, 0, 0, 0, 0, 0);
    send_bits(32'hDEADBEEF, 0, 0, 31, -1, 0);
    tick(1, 0, 0, 0, 0, 1);
    check("ovr_err", {31'd0, err}, 32'd1);
    check("ovr_Q", Q, 32'hDEADBEEF);
    check("ovr_valid", {31'd0, valid}, 32'd1);
    tick(1, 0, 0, 1, 0, 1);
    check("ovr_drop_busy", {31'd0, busy}, 32'd0);
    check("ovr_drop_err", {31'd0, err}, 32'd1);
    tick(1, 0, 0, 0, 0, 1);
    check("ovr_restart_err", {31'd0, err}, 32'd0);
    check("ovr_restart_busy", {31'd0, busy}, 32'd1);
    send_bits(32'h0F0F1234, 1, 0, 31, -1, 0);
    check("ovr_new_Q", Q, 32'h0F0F1234);
    do_ack(1);

    // Reset after 17 bits, then all-ones word
    tick(1, 0, 0, 0, 0, 1);
    send_bits(32'h5555AAAA, 1, 0, 16, -1, 0);
    tick(0, 1, 1, 0, 1, 1);
    check("mid_rst_Q", Q, 32'h0);
    check("mid_rst_flags", {29'd0, valid, busy, err}, 32'd0);
    tick(1, 0, 0, 0, 0, 0);
    send_bits(32'hFFFFFFFF, 0, 0, 31, -1, 0);
    check("ones_Q", Q, 32'hFFFFFFFF);
    do_ack(0);

    // Start re-pulsed at bit 10 is ignored
    tick(1, 0, 0, 0, 0, 1);
    send_bits(32'hC3C3_0101, 1, 0, 30, 10, 0);
    check("restart_pre_valid", {31'd0, valid}, 32'd0);
    send_bits(32'hC3C3_0101, 1, 31, 31, -1, 0);
    check("restart_valid", {31'd0, valid}, 32'd1);
    check("restart_Q", Q, 32'hC3C3_0101);
    do_ack(1);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
